// File: rtl/dds_pkg.sv
// Shared defaults, quadrant type and quarter-wave table generator for the multichannel NCO.
package dds_pkg;
  localparam int DEF_PW = 32;
  localparam int DEF_AW = 10;
  localparam int DEF_OW = 12;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  // Half-LSB phase offset keeps the table free of a zero entry and a mirrored duplicate.
  function automatic int qsin_val(input int k, input int aw, input int ow);
    real pk, ang;
    pk  = real'((1 << (ow - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << aw);
    return $rtoi(pk * $sin(ang) + 0.5);
  endfunction
endpackage

// File: rtl/dds_nco_mc_if.sv
// Control/write bus and tagged I/Q output bus of the multichannel NCO.
interface dds_nco_mc_if #(
  parameter int NCH = 4,
  parameter int PW  = 32,
  parameter int OW  = 12
);
  localparam int CW = $clog2(NCH);

  logic                 en;
  logic                 wr;
  logic                 wsel;
  logic [CW-1:0]        wch;
  logic [PW-1:0]        wdat;
  logic                 sync;
  logic signed [OW-1:0] dout_i;
  logic signed [OW-1:0] dout_q;
  logic [CW-1:0]        dout_ch;
  logic                 dout_vld;

  modport master (output en, wr, wsel, wch, wdat, sync,
                  input  dout_i, dout_q, dout_ch, dout_vld);
  modport slave  (input  en, wr, wsel, wch, wdat, sync,
                  output dout_i, dout_q, dout_ch, dout_vld);
endinterface

// File: rtl/dds_qsin_rom.sv
// Registered quarter-wave sine ROM, 2^(AW-2) x (OW-1) magnitudes, one read per clock.
module dds_qsin_rom #(
  parameter int AW = dds_pkg::DEF_AW,
  parameter int OW = dds_pkg::DEF_OW
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic [AW-3:0] addr,
  output logic [OW-2:0] dat
);
  import dds_pkg::*;
  localparam int DEPTH = 1 << (AW - 2);

  logic [DEPTH-1:0][OW-2:0] tab;
  logic [OW-2:0]            dat_q, dat_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam int VAL = qsin_val(k, AW, OW);
    assign tab[k] = VAL[OW-2:0];
  end

  assign dat_d = tab[addr];

  always_ff @(posedge sclk or posedge rst)
    if (rst) dat_q <= '0;
    else     dat_q <= dat_d;

  assign dat = dat_q;
endmodule

// File: rtl/dds_nco_mc.sv
// Time-multiplexed NCH-channel quadrature NCO: phase stage, quarter-wave ROM stage, sign stage.
// Define DDS_DITHER_EN to add LFSR phase dither ahead of truncation.
module dds_nco_mc #(
  parameter int NCH = 4,
  parameter int PW  = dds_pkg::DEF_PW,
  parameter int AW  = dds_pkg::DEF_AW,
  parameter int OW  = dds_pkg::DEF_OW
) (
  input logic         sclk,
  input logic         rst,
  dds_nco_mc_if.slave bus
);
  import dds_pkg::*;
  localparam int CW     = $clog2(NCH);
  localparam int RAW    = AW - 2;
  localparam int STAGES = 3;

  logic [NCH-1:0][PW-1:0] acc_q, acc_d, frq_q, frq_d, poff_q, poff_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [PW-1:0]          phase, dith;
  logic [AW-1:0]          idx_q, idx_d;
  logic [STAGES-1:0]      vld_pipe_q, vld_pipe_d;
  logic [1:0][CW-1:0]     chp_q, chp_d;
  logic                   neg_s_q, neg_s_d, neg_c_q, neg_c_d;
  logic signed [OW-1:0]   dout_i_q, dout_i_d, dout_q_q, dout_q_d;
  logic [CW-1:0]          dout_ch_q, dout_ch_d;
  logic signed [OW-1:0]   mag_s, mag_c;
  logic [1:0][RAW-1:0]    rom_addr;
  logic [1:0][OW-2:0]     rom_dat;
  quad_e                  qs, qc;
  logic                   svc;

  assign svc = bus.en && !bus.sync;

`ifdef DDS_DITHER_EN
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (svc) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
  end

  always_ff @(posedge sclk or posedge rst)
    if (rst) lfsr_q <= 32'd1;
    else     lfsr_q <= lfsr_d;

  assign dith = PW'(lfsr_q[PW-AW-1:0]);
`else
  assign dith = '0;
`endif

  // Stage 0: phase uses the pre-update accumulator; writes land behind the service read.
  assign phase = acc_q[ch_q] + poff_q[ch_q] + dith;
  assign idx_d = AW'(phase >> (PW - AW));

  always_comb begin
    acc_d  = acc_q;
    frq_d  = frq_q;
    poff_d = poff_q;
    ch_d   = ch_q;
    if (bus.sync) begin
      acc_d = '0;
      ch_d  = '0;
    end else if (bus.en) begin
      acc_d[ch_q] = acc_q[ch_q] + frq_q[ch_q];
      ch_d        = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
    end
    if (bus.wr && (int'(bus.wch) < NCH)) begin
      if (bus.wsel) poff_d[bus.wch] = bus.wdat;
      else          frq_d[bus.wch]  = bus.wdat;
    end
  end

  // Stage 1: cosine leads sine by one quadrant; odd quadrants read the table backwards.
  assign qs = quad_e'(idx_q[AW-1 -: 2]);
  assign qc = quad_e'(idx_q[AW-1 -: 2] + 2'd1);
  assign rom_addr[0] = (qs == Q1 || qs == Q3) ? ~idx_q[RAW-1:0] : idx_q[RAW-1:0];
  assign rom_addr[1] = (qc == Q1 || qc == Q3) ? ~idx_q[RAW-1:0] : idx_q[RAW-1:0];

  for (genvar r = 0; r < 2; r++) begin : g_rom
    dds_qsin_rom #(.AW(AW), .OW(OW)) u_rom (
      .sclk (sclk),
      .rst  (rst),
      .addr (rom_addr[r]),
      .dat  (rom_dat[r])
    );
  end

  // Stage 2: restore sign for the lower half-circle.
  assign mag_s = {1'b0, rom_dat[0]};
  assign mag_c = {1'b0, rom_dat[1]};

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], svc};
    chp_d      = {chp_q[0], ch_q};
    neg_s_d    = (qs == Q2) || (qs == Q3);
    neg_c_d    = (qc == Q2) || (qc == Q3);
    dout_i_d   = dout_i_q;
    dout_q_d   = dout_q_q;
    dout_ch_d  = dout_ch_q;
    if (vld_pipe_q[1]) begin
      dout_i_d  = neg_c_q ? -mag_c : mag_c;
      dout_q_d  = neg_s_q ? -mag_s : mag_s;
      dout_ch_d = chp_q[1];
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      frq_q      <= '0;
      poff_q     <= '0;
      ch_q       <= '0;
      idx_q      <= '0;
      vld_pipe_q <= '0;
      chp_q      <= '0;
      neg_s_q    <= 1'b0;
      neg_c_q    <= 1'b0;
      dout_i_q   <= '0;
      dout_q_q   <= '0;
      dout_ch_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      frq_q      <= frq_d;
      poff_q     <= poff_d;
      ch_q       <= ch_d;
      idx_q      <= idx_d;
      vld_pipe_q <= vld_pipe_d;
      chp_q      <= chp_d;
      neg_s_q    <= neg_s_d;
      neg_c_q    <= neg_c_d;
      dout_i_q   <= dout_i_d;
      dout_q_q   <= dout_q_d;
      dout_ch_q  <= dout_ch_d;
    end
  end

  assign bus.dout_i   = dout_i_q;
  assign bus.dout_q   = dout_q_q;
  assign bus.dout_ch  = dout_ch_q;
  assign bus.dout_vld = vld_pipe_q[STAGES-1];
endmodule

// File: tb/tb_dds_nco_mc.sv
// Directed bench for dds_nco_mc (NCH=4 main instance, NCH=5 instance for out-of-range writes).
module tb_dds_nco_mc;
  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  dds_nco_mc_if #(.NCH(4), .PW(32), .OW(12)) bus ();
  dds_nco_mc #(.NCH(4), .PW(32), .AW(10), .OW(12)) dut (.sclk(sclk), .rst(rst), .bus(bus));

  dds_nco_mc_if #(.NCH(5), .PW(32), .OW(12)) bus5 ();
  dds_nco_mc #(.NCH(5), .PW(32), .AW(10), .OW(12)) dut5 (.sclk(sclk), .rst(rst), .bus(bus5));

  int nassert = 0;
  int nfail   = 0;

  // Channel 0..3 after coherent restart, three turns: ch0 frq=1/2 cycle, ch1 +90, ch2 +180, ch3 slow ramp.
  int exp_i [12] = '{2047, -6, -2047, 2047, -2047, -6, -2047, 2047, 2047, -6, -2047, 2047};
  int exp_q [12] = '{6, 2047, -6, 6, -6, 2047, -6, 19, 6, 2047, -6, 31};

  function automatic logic [28:0] pk(input logic v, input int c, input int i, input int q);
    return {v, 4'(c), 12'(i), 12'(q)};
  endfunction

  function automatic logic [28:0] obs4();
    return {bus.dout_vld, 4'(bus.dout_ch), bus.dout_i, bus.dout_q};
  endfunction

  function automatic logic [28:0] obs5();
    return {bus5.dout_vld, 4'(bus5.dout_ch), bus5.dout_i, bus5.dout_q};
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got vld=%0d ch=%0d i=%0d q=%0d, expected vld=%0d ch=%0d i=%0d q=%0d",
             tag, obs[28], obs[27:24], $signed(obs[23:12]), $signed(obs[11:0]),
             exp[28], exp[27:24], $signed(exp[23:12]), $signed(exp[11:0]));
    end
  endtask

  task automatic chk_vld(input string tag, input logic v, input logic exp);
    chk(tag, pk(v, 0, 0, 0), pk(exp, 0, 0, 0));
  endtask

  task automatic wreg(input logic sel, input int ch, input logic [31:0] dat);
    bus.wr = 1'b1; bus.wsel = sel; bus.wch = 2'(ch); bus.wdat = dat;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic wreg5(input logic sel, input int ch, input logic [31:0] dat);
    bus5.wr = 1'b1; bus5.wsel = sel; bus5.wch = 3'(ch); bus5.wdat = dat;
    tick();
    bus5.wr = 1'b0;
  endtask

  initial begin
    bus.en = 0; bus.wr = 0; bus.wsel = 0; bus.wch = '0; bus.wdat = '0; bus.sync = 0;
    bus5.en = 0; bus5.wr = 0; bus5.wsel = 0; bus5.wch = '0; bus5.wdat = '0; bus5.sync = 0;

    // Reset state, then all-zero words: every sample is phase 0.
    #12;
    chk("reset", obs4(), pk(0, 0, 0, 0));
    chk("reset5", obs5(), pk(0, 0, 0, 0));
    rst = 1'b0;
    bus.en = 1'b1;
    tick(); chk_vld("lat1", bus.dout_vld, 1'b0);
    tick(); chk_vld("lat2", bus.dout_vld, 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick(); chk("zero_smp", obs4(), pk(1, n % 4, 2047, 6));
    end

    // Drain; data holds the last sample (ch1, serviced tenth).
    bus.en = 1'b0;
    tick(); tick(); tick();
    chk("drain_hold", obs4(), pk(0, 1, 2047, 6));

    wreg(1'b1, 1, 32'h4000_0000);
    wreg(1'b1, 2, 32'h8000_0000);
    wreg(1'b0, 0, 32'h8000_0000);
    wreg(1'b0, 3, 32'h0040_0000);
    bus.sync = 1'b1; tick(); bus.sync = 1'b0;

    bus.en = 1'b1;
    tick(); tick(); chk_vld("restart_lat", bus.dout_vld, 1'b0);
    for (int n = 0; n < 12; n++) begin
      tick(); chk("pattern", obs4(), pk(1, n % 4, exp_i[n], exp_q[n]));
    end
    // ch3 idx == turn number: last point of the circle, then clean wrap.
    for (int n = 12; n < 4100; n++) begin
      tick();
      if (n == 4095) chk("ch3_idx1023", obs4(), pk(1, 3, 2047, -6));
      if (n == 4096) chk("ch0_even", obs4(), pk(1, 0, 2047, 6));
      if (n == 4098) chk("ch2_steady", obs4(), pk(1, 2, -2047, -6));
      if (n == 4099) chk("ch3_wrap", obs4(), pk(1, 3, 2047, 6));
    end

    // Coherent restart while running; two in-flight samples drain first.
    bus.sync = 1'b1; tick(); bus.sync = 1'b0;
    chk("sync_drain0", obs4(), pk(1, 0, -2047, -6));
    tick(); chk("sync_drain1", obs4(), pk(1, 1, -6, 2047));
    tick(); chk_vld("sync_gap", bus.dout_vld, 1'b0);
    // Next edge services ch2: write its frequency in that same cycle.
    bus.wr = 1'b1; bus.wsel = 1'b0; bus.wch = 2'd2; bus.wdat = 32'h8000_0000;
    tick(); bus.wr = 1'b0;
    chk("sync_ch0", obs4(), pk(1, 0, 2047, 6));
    tick(); chk("sync_ch1", obs4(), pk(1, 1, -6, 2047));
    tick(); chk("ch2_turn0", obs4(), pk(1, 2, -2047, -6));
    tick(); chk("sync_ch3", obs4(), pk(1, 3, 2047, 6));
    tick(); tick(); tick(); chk("ch2_turn1_old", obs4(), pk(1, 2, -2047, -6));
    tick(); tick(); tick(); tick(); chk("ch2_turn2_new", obs4(), pk(1, 2, 2047, 6));

    // en 1,0,1 -> dout_vld 1,0,1 with the gap holding data.
    bus.en = 1'b0; tick();
    bus.en = 1'b1; tick();
    chk("gap_v1", obs4(), pk(1, 0, -2047, -6));
    tick(); chk("gap_v0", obs4(), pk(0, 0, -2047, -6));
    tick(); chk("gap_v1b", obs4(), pk(1, 1, -6, 2047));

    // Asynchronous reset mid-run.
    #2 rst = 1'b1;
    #1 chk("rst_async", obs4(), pk(0, 0, 0, 0));
    bus.en = 1'b0;
    tick();
    rst = 1'b0;

    // Out-of-range channel writes are dropped (NCH=5, wch 5..7).
    wreg5(1'b0, 5, 32'h8000_0000);
    wreg5(1'b1, 7, 32'h4000_0000);
    wreg5(1'b1, 6, 32'hC000_0000);
    wreg5(1'b1, 4, 32'h4000_0000);
    bus5.en = 1'b1;
    tick(); tick();
    for (int n = 0; n < 10; n++) begin
      tick();
      if (n % 5 == 4) chk("oor_ch4", obs5(), pk(1, 4, -6, 2047));
      else            chk("oor_smp", obs5(), pk(1, n % 5, 2047, 6));
    end
    chk("idle_main", obs4(), pk(0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
